// File: rtl/fpu_pkg.sv
// Shared constants and helpers for the floating-point adder datapath.
//   SINGLE_FRAC_W / DOUBLE_FRAC_W : fraction widths with hidden bit
//   GRS_W                         : guard/round/sticky extension width
//   calc_rw()                     : result width (fraction + GRS + carry bit)
package fpu_pkg;

  localparam int SINGLE_FRAC_W = 24;
  localparam int DOUBLE_FRAC_W = 53;
  localparam int GRS_W         = 3;

  function automatic int calc_rw(input int frac_w, input int grs_w);
    return frac_w + grs_w + 1;
  endfunction

endpackage

// File: rtl/fadd_frac_alu.sv
// Combinational fraction add/subtract with magnitude output.
//   op_sub_i     : 1 = large - small, 0 = large + small
//   large_frac_i : larger-magnitude fraction, hidden bit included
//   small_frac_i : aligned smaller fraction carrying GRS bits
//   mag_o        : result magnitude, MSB is the carry-out position
//   carry_o      : mag_o MSB set
//   zero_o       : result exactly zero
//   neg_o        : raw difference was negative, mag_o is its negation
module fadd_frac_alu #(
  parameter int FRAC_W = fpu_pkg::SINGLE_FRAC_W,
  parameter int GRS_W  = fpu_pkg::GRS_W
) (
  input  logic                      op_sub_i,
  input  logic [FRAC_W-1:0]         large_frac_i,
  input  logic [FRAC_W+GRS_W-1:0]   small_frac_i,
  output logic [FRAC_W+GRS_W:0]     mag_o,
  output logic                      carry_o,
  output logic                      zero_o,
  output logic                      neg_o
);

  localparam int RW = fpu_pkg::calc_rw(FRAC_W, GRS_W);

  logic [RW:0]   large_ext;
  logic [RW:0]   small_ext;
  logic [RW:0]   raw;
  logic [RW-1:0] raw_neg;

  // One spare bit above the carry position acts as the sign of a subtraction.
  assign large_ext = {2'b00, large_frac_i, {GRS_W{1'b0}}};
  assign small_ext = {2'b00, small_frac_i};

  assign raw     = op_sub_i ? (large_ext - small_ext) : (large_ext + small_ext);
  assign raw_neg = ~raw[RW-1:0] + {{(RW-1){1'b0}}, 1'b1};

  // An add can never set the sign bit, so gating with op_sub_i is only for clarity.
  assign neg_o   = op_sub_i & raw[RW];
  assign mag_o   = neg_o ? raw_neg : raw[RW-1:0];
  assign carry_o = mag_o[RW-1];
  assign zero_o  = (mag_o == '0);

endmodule

// File: rtl/fadd_cal_pipe.sv
// Two-stage pipelined fraction add/subtract between alignment and normalisation.
// S1 registers the operands, S2 registers the ALU result and flags.
//   clk, clrn              : clock, synchronous active-low reset
//   in_valid / in_ready    : upstream handshake
//   op_sub                 : 1 = subtract, 0 = add
//   large_frac, small_frac : operands (small carries GRS bits)
//   in_tag / out_tag       : side-band context travelling with the operation
//   out_valid / out_ready  : downstream handshake
//   cal_frac               : result magnitude, MSB is carry-out position
//   carry, zero, neg       : result flags
module fadd_cal_pipe #(
  parameter int FRAC_W = fpu_pkg::SINGLE_FRAC_W,
  parameter int GRS_W  = fpu_pkg::GRS_W,
  parameter int TAG_W  = 10
) (
  input  logic                     clk,
  input  logic                     clrn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [FRAC_W-1:0]        large_frac,
  input  logic [FRAC_W+GRS_W-1:0]  small_frac,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [FRAC_W+GRS_W:0]    cal_frac,
  output logic                     carry,
  output logic                     zero,
  output logic                     neg,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int RW = fpu_pkg::calc_rw(FRAC_W, GRS_W);

  logic                     s1_valid_q;
  logic                     s1_valid_d;
  logic                     s1_op_sub_q;
  logic [FRAC_W-1:0]        s1_large_q;
  logic [FRAC_W+GRS_W-1:0]  s1_small_q;
  logic [TAG_W-1:0]         s1_tag_q;

  logic                     s2_valid_q;
  logic                     s2_valid_d;
  logic [RW-1:0]            cal_frac_q;
  logic                     carry_q;
  logic                     zero_q;
  logic                     neg_q;
  logic [TAG_W-1:0]         out_tag_q;

  logic                     s1_adv;
  logic                     s2_adv;
  logic                     s1_load;
  logic                     s2_load;

  logic [RW-1:0]            alu_mag;
  logic                     alu_carry;
  logic                     alu_zero;
  logic                     alu_neg;

  // Stall propagates backwards combinationally so a full pipe never drops data.
  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Data registers only move when a real operation arrives, so held outputs
  // stay put while the pipe is empty.
  assign s1_load    = in_valid & s1_adv;
  assign s2_load    = s1_valid_q & s2_adv;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;

  fadd_frac_alu #(
    .FRAC_W (FRAC_W),
    .GRS_W  (GRS_W)
  ) u_alu (
    .op_sub_i     (s1_op_sub_q),
    .large_frac_i (s1_large_q),
    .small_frac_i (s1_small_q),
    .mag_o        (alu_mag),
    .carry_o      (alu_carry),
    .zero_o       (alu_zero),
    .neg_o        (alu_neg)
  );

  always_ff @(posedge clk) begin
    if (!clrn) begin
      s1_valid_q  <= 1'b0;
      s1_op_sub_q <= 1'b0;
      s1_large_q  <= '0;
      s1_small_q  <= '0;
      s1_tag_q    <= '0;
      s2_valid_q  <= 1'b0;
      cal_frac_q  <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
      out_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (s1_load) begin
        s1_op_sub_q <= op_sub;
        s1_large_q  <= large_frac;
        s1_small_q  <= small_frac;
        s1_tag_q    <= in_tag;
      end
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        cal_frac_q <= alu_mag;
        carry_q    <= alu_carry;
        zero_q     <= alu_zero;
        neg_q      <= alu_neg;
        out_tag_q  <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign cal_frac  = cal_frac_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign out_tag   = out_tag_q;

endmodule

// File: doc/fadd_cal_pipe.md
# fadd_cal_pipe

Parametrised, two-stage pipelined fraction add/subtract stage for the floating-point adder datapath, sitting between the alignment stage and the normalisation stage. It adds or subtracts a hidden-bit-inclusive large fraction and an aligned small fraction that carries guard/round/sticky bits. It flags carry-out, zero and negative results, and returns a magnitude so normalisation never sees a two's-complement value. Valid/ready handshaking on both sides lets pipeline stalls propagate without losing data. A tag field carries sign/exponent/rounding-mode context alongside the data.

## Interface
Parameters:
- FRAC_W, 24: fraction width including hidden bit (24 single, 53 double)
- GRS_W, 3: guard/round/sticky extension bits on small operand
- TAG_W, 10: opaque side-band context carried with each operation

Ports (clock and reset first):
- clk  in  1  clock; all state changes on rising edge
- clrn  in  1  synchronous active-low reset, sampled on rising edge of clk
- in_valid  in  1  input operation present
- in_ready  out  1  stage can accept input this cycle
- op_sub  in  1  1 = subtract, 0 = add
- large_frac  in  FRAC_W  larger-magnitude fraction, hidden bit included
- small_frac  in  FRAC_W+GRS_W  aligned smaller fraction with GRS bits
- in_tag  in  TAG_W  side-band context
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result
- cal_frac  out  FRAC_W+GRS_W+1  result magnitude; MSB is carry-out position
- carry  out  1  cal_frac MSB set (add overflow, needs right-normalise)
- zero  out  1  result exactly 0
- neg  out  1  raw difference was negative; cal_frac is negated magnitude
- out_tag  out  TAG_W  in_tag of same operation

## Operation
- Width rule: RW = FRAC_W+GRS_W+1. Operands extend to RW+1 bits: large = {2'b0, large_frac, GRS_W zeros}; small = {2'b0, small_frac}.
- Stage 1 (S1) registers op_sub, operands and tag on an accepted transfer (in_valid & in_ready).
- Stage 2 (S2) computes raw = large ± small in RW+1 bits.
  - Sub: raw bit RW set means negative. The stage sets neg=1 and cal_frac = (−raw)[RW-1:0].
  - Add: neg=0 and cal_frac = raw[RW-1:0].
- carry = cal_frac[RW-1]. It can only be set on add.
- zero = (cal_frac == 0), so neg=0 and carry=0 on a zero result.
- The stage registers all S2 results, the flags and out_tag. Outputs are held stable while out_valid & !out_ready.
- Handshake:
  - s2_adv = !s2_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
- Each stage loads when its advance term is true. Its valid bit takes the upstream valid.
- This is a fully occupied pipeline with no bubbles at sustained throughput of 1 operation per cycle.
- Reset (clrn=0 at an edge): s1_valid=0, s2_valid=0, out_valid=0, cal_frac=0, carry=0, zero=0, neg=0, out_tag=0. Data in flight is discarded.
- in_ready is 1 in the first cycle after reset is released.

## Timing
- Latency: 2 cycles from an accepted input edge to out_valid, with no stall.
- Throughput: one operation per cycle while out_ready=1.
- Stall with out_ready=0 and both stages full: in_ready=0 in that same cycle (combinational path from out_ready). No data is overwritten or dropped.
- Simultaneous drain and fill: with s2 full and out_ready=1, S2 loads from S1 in the same edge that S1 accepts new input.
- Reset mid-stall: both valids clear at the edge and in_ready=1 next cycle.
- out_valid never depends combinationally on in_valid.

## Structure
- Shared package fpu_pkg:
  - localparams SINGLE_FRAC_W=24, DOUBLE_FRAC_W=53, GRS_W=3
  - a function computing RW from FRAC_W/GRS_W
- Sub-module fadd_frac_alu: combinational RW+1-bit add/sub producing magnitude, carry, zero and neg. It is instantiated once in S2.
- Pipeline registers and handshake logic live in fadd_cal_pipe.

## Test plan
- FRAC_W=24, add: large_frac=24'h800000, small_frac=27'h4000000, op_sub=0 -> two cycles later cal_frac=28'h8000000, carry=1, neg=0, zero=0.
- Sub equal operands: large_frac=24'hC00000, small_frac=27'h6000000, op_sub=1 -> cal_frac=0, zero=1, neg=0, carry=0.
- Sub negative: large_frac=24'h800000, small_frac=27'h4000008, op_sub=1 -> neg=1, cal_frac=28'h0000008.
- Back-pressure: 4 back-to-back ops with out_ready=0 from cycle 2 for 3 cycles:
  - in_ready drops after 2 accepted ops.
  - out_valid, cal_frac and out_tag stay stable.
  - All 4 results emerge in order once out_ready=1.
- Reset mid-stream: clrn=0 for one edge with both stages full -> out_valid=0 and all outputs 0 next cycle; no stale result is emitted afterwards.
- FRAC_W=53: random 1000 ops with random out_ready checked against a reference model for cal_frac/carry/zero/neg/tag ordering.
